// File: rtl/solitaire_pkg.sv
// Shared card-game definitions: suits, card field layout, pile and deck constants, FSM states.
// Card word: [6:3] rank 1..13, [2:1] suit, [0] face-up.
// The SHUFFLE state exists only when SHUFFLE_EN is defined.
package solitaire_pkg;

    localparam logic [1:0] HEARTS   = 2'd0;
    localparam logic [1:0] SPADES   = 2'd1;
    localparam logic [1:0] DIAMONDS = 2'd2;
    localparam logic [1:0] CLUBS    = 2'd3;

    localparam int CARD_RANK_MSB = 6;
    localparam int CARD_RANK_LSB = 3;
    localparam int CARD_SUIT_MSB = 2;
    localparam int CARD_SUIT_LSB = 1;
    localparam int CARD_FACE_BIT = 0;

    localparam logic [2:0] PILE_STOCK = 3'd7;
    localparam int         DECK_SIZE  = 52;

    localparam logic [5:0] LAST_IDX          = 6'(DECK_SIZE - 1);
    localparam logic [5:0] NUM_TABLEAU_CARDS = 6'd28;
    localparam logic [5:0] TABLEAU_LAST      = 6'd27;
    localparam logic [5:0] STOCK_LAST        = 6'd23;
    localparam logic [2:0] LAST_COL          = 3'd6;
    localparam logic [5:0] LFSR_SEED         = 6'h3F;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
`ifdef SHUFFLE_EN
        S_SHUFFLE,
`endif
        S_DEAL,
        S_STOCK,
        S_FIN
    } deal_state_t;

    // Fresh-deck card for slot i: four suits per rank, face down.
    function automatic logic [6:0] init_card(input logic [5:0] i);
        logic [6:0] c;
        c = '0;
        c[CARD_RANK_MSB:CARD_RANK_LSB] = i[5:2] + 4'd1;
        c[CARD_SUIT_MSB:CARD_SUIT_LSB] = i[1:0];
        return c;
    endfunction

    function automatic logic [6:0] set_face(input logic [6:0] c, input logic up);
        logic [6:0] r;
        r = c;
        r[CARD_FACE_BIT] = up;
        return r;
    endfunction

endpackage

// File: rtl/deal_lfsr.sv
// 6-bit maximal-length Fibonacci LFSR (x^6 + x^5 + 1) used as the shuffle random source.
// Latency: new value the cycle after en.
// Backpressure: none; holds its value while en is low.
module deal_lfsr
    import solitaire_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic [5:0] lfsr
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr <= LFSR_SEED;
        end else if (en) begin
            lfsr <= {lfsr[4:0], lfsr[5] ^ lfsr[4]};
        end
    end

endmodule

// File: rtl/deal_controller.sv
// Builds a 52-card deck in external RAM, optionally shuffles it (SHUFFLE_EN), deals Klondike tableau then stock.
// Latency: 52 init cycles, up to 4 cycles per shuffle step, 2 cycles per dealt card with pile_ready high.
// Backpressure: pile outputs hold while pile_valid && !pile_ready; the deal pointer advances only on accept.
module deal_controller
    import solitaire_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic [5:0] deck_addr,
    output logic       deck_we,
    output logic [6:0] deck_wdata,
    input  logic [6:0] deck_rdata,
    output logic       pile_valid,
    input  logic       pile_ready,
    output logic [2:0] pile_sel,
    output logic [4:0] pile_idx,
    output logic [6:0] pile_card
);

    deal_state_t state, state_nx;
    logic [5:0]  cnt, cnt_nx;
    logic [2:0]  row, row_nx, col, col_nx;
    logic [1:0]  ph, ph_nx;

`ifdef SHUFFLE_EN
    logic [5:0] j_q, j_nx;
    logic [6:0] a_q, a_nx;
    logic       lfsr_en;
    logic [5:0] lfsr;

    deal_lfsr u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .en   (lfsr_en),
        .lfsr (lfsr)
    );
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
            row   <= '0;
            col   <= '0;
            ph    <= '0;
`ifdef SHUFFLE_EN
            j_q   <= '0;
            a_q   <= '0;
`endif
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            row   <= row_nx;
            col   <= col_nx;
            ph    <= ph_nx;
`ifdef SHUFFLE_EN
            j_q   <= j_nx;
            a_q   <= a_nx;
`endif
        end
    end

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        row_nx     = row;
        col_nx     = col;
        ph_nx      = ph;
        busy       = (state != S_IDLE);
        done       = 1'b0;
        deck_addr  = '0;
        deck_we    = 1'b0;
        deck_wdata = '0;
        pile_valid = 1'b0;
        pile_sel   = '0;
        pile_idx   = '0;
        pile_card  = '0;
`ifdef SHUFFLE_EN
        j_nx       = j_q;
        a_nx       = a_q;
        lfsr_en    = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx = S_INIT;
                    cnt_nx   = '0;
                end
            end
            S_INIT: begin
                deck_addr  = cnt;
                deck_we    = 1'b1;
                deck_wdata = init_card(cnt);
                ph_nx      = '0;
                if (cnt == LAST_IDX) begin
`ifdef SHUFFLE_EN
                    state_nx = S_SHUFFLE;
                    cnt_nx   = LAST_IDX;
`else
                    state_nx = S_DEAL;
                    cnt_nx   = '0;
                    row_nx   = '0;
                    col_nx   = '0;
`endif
                end else begin
                    cnt_nx = cnt + 6'd1;
                end
            end
`ifdef SHUFFLE_EN
            // Read deck[i], read deck[j] while latching deck[i], write deck[j] into i, then deck[i] into j.
            S_SHUFFLE: begin
                ph_nx = ph + 2'd1;
                case (ph)
                    2'd0: begin
                        deck_addr = cnt;
                        j_nx      = lfsr % (cnt + 6'd1);
                    end
                    2'd1: begin
                        deck_addr = j_q;
                        a_nx      = deck_rdata;
                    end
                    2'd2: begin
                        deck_addr  = cnt;
                        deck_we    = 1'b1;
                        deck_wdata = deck_rdata;
                    end
                    default: begin
                        deck_addr  = j_q;
                        deck_we    = 1'b1;
                        deck_wdata = a_q;
                        lfsr_en    = 1'b1;
                        if (cnt == 6'd1) begin
                            state_nx = S_DEAL;
                            cnt_nx   = '0;
                            row_nx   = '0;
                            col_nx   = '0;
                        end else begin
                            cnt_nx = cnt - 6'd1;
                        end
                    end
                endcase
            end
`endif
            // Phase 0 presents the address; phase 1 offers the RAM output while the address is held.
            S_DEAL: begin
                deck_addr = cnt;
                if (ph == 2'd0) begin
                    ph_nx = 2'd1;
                end else begin
                    pile_valid = 1'b1;
                    pile_sel   = col;
                    pile_idx   = {2'b00, row};
                    pile_card  = set_face(deck_rdata, col == row);
                    if (pile_ready) begin
                        ph_nx = 2'd0;
                        if (cnt == TABLEAU_LAST) begin
                            state_nx = S_STOCK;
                            cnt_nx   = '0;
                        end else begin
                            cnt_nx = cnt + 6'd1;
                            if (col == LAST_COL) begin
                                row_nx = row + 3'd1;
                                col_nx = row + 3'd1;
                            end else begin
                                col_nx = col + 3'd1;
                            end
                        end
                    end
                end
            end
            S_STOCK: begin
                deck_addr = NUM_TABLEAU_CARDS + cnt;
                if (ph == 2'd0) begin
                    ph_nx = 2'd1;
                end else begin
                    pile_valid = 1'b1;
                    pile_sel   = PILE_STOCK;
                    pile_idx   = cnt[4:0];
                    pile_card  = set_face(deck_rdata, 1'b0);
                    if (pile_ready) begin
                        ph_nx = 2'd0;
                        if (cnt == STOCK_LAST) begin
                            state_nx = S_FIN;
                        end else begin
                            cnt_nx = cnt + 6'd1;
                        end
                    end
                end
            end
            S_FIN: begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

endmodule
